// File: rtl/axis_hdr_strip_if.sv
// AXI-Stream beat bundle shared by the header stripper's input and output sides.
// The master drives data/valid/last, the slave drives ready.
interface axis_hdr_strip_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_hdr_strip.sv
// Strips and checks the magic header beat of each AXI-Stream frame and forwards the payload
// through a registered output stage; bad-header frames are dropped up to their tlast.
module axis_hdr_strip #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] HDR_MAGIC  = DATA_WIDTH'(32'hDEADBEEF),
    parameter int unsigned           CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    axis_hdr_strip_if.slave      s_axis,
    axis_hdr_strip_if.master     m_axis,
    output logic [CNT_WIDTH-1:0] frm_ok_cnt,
    output logic [CNT_WIDTH-1:0] hdr_err_cnt,
    output logic [CNT_WIDTH-1:0] runt_cnt,
    output logic                 in_frame
);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PASS = 2'd1,
        S_DROP = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic                  m_valid_q;
    logic                  m_last_q;

    logic                  load_c;
    logic                  s_ready_c;
    logic                  accept_c;
    logic                  hdr_ok_c;
    logic                  pass_load_c;
    logic                  inc_ok_c;
    logic                  inc_err_c;
    logic                  inc_runt_c;

    // Handshake, next-state and counter-event decode.
    always_comb begin
        load_c      = ~m_valid_q | m_axis.tready;
        s_ready_c   = 1'b1;
        state_nxt   = state;
        inc_ok_c    = 1'b0;
        inc_err_c   = 1'b0;
        inc_runt_c  = 1'b0;
        pass_load_c = 1'b0;
        hdr_ok_c    = (s_axis.tdata == HDR_MAGIC);

        if (state == S_PASS) begin
            s_ready_c = load_c;
        end
        accept_c = s_axis.tvalid & s_ready_c;

        case (state)
            S_HDR: begin
                if (accept_c) begin
                    if (hdr_ok_c) begin
                        if (s_axis.tlast) begin
                            inc_runt_c = 1'b1;
                        end else begin
                            state_nxt = S_PASS;
                        end
                    end else begin
                        inc_err_c = 1'b1;
                        if (!s_axis.tlast) begin
                            state_nxt = S_DROP;
                        end
                    end
                end
            end
            S_PASS: begin
                if (accept_c) begin
                    pass_load_c = 1'b1;
                    if (s_axis.tlast) begin
                        inc_ok_c  = 1'b1;
                        state_nxt = S_HDR;
                    end
                end
            end
            S_DROP: begin
                if (accept_c && s_axis.tlast) begin
                    state_nxt = S_HDR;
                end
            end
            default: begin
                state_nxt = S_HDR;
            end
        endcase
    end

    // State, output stage and saturating statistics.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_HDR;
            in_frame    <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            frm_ok_cnt  <= '0;
            hdr_err_cnt <= '0;
            runt_cnt    <= '0;
        end else begin
            state    <= state_nxt;
            in_frame <= (state_nxt != S_HDR);

            // A reload in the same cycle as an output handshake keeps valid high.
            if (pass_load_c) begin
                m_data_q  <= s_axis.tdata;
                m_last_q  <= s_axis.tlast;
                m_valid_q <= 1'b1;
            end else if (m_axis.tready) begin
                m_valid_q <= 1'b0;
            end

            if (inc_ok_c && (frm_ok_cnt != CNT_MAX)) begin
                frm_ok_cnt <= frm_ok_cnt + CNT_WIDTH'(1);
            end
            if (inc_err_c && (hdr_err_cnt != CNT_MAX)) begin
                hdr_err_cnt <= hdr_err_cnt + CNT_WIDTH'(1);
            end
            if (inc_runt_c && (runt_cnt != CNT_MAX)) begin
                runt_cnt <= runt_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign s_axis.tready = s_ready_c;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_last_q;

endmodule
